// File: rtl/sprite_fetch.sv
// Sprite ROM read initiator: maps the scan position into the sprite box and drives the ROM address.
// It aligns the returned palette with a 2-clock pipeline, masks the transparency key and flags background collisions.
module sprite_fetch #(
  parameter int unsigned SPR_W   = 30,
  parameter int unsigned SPR_H   = 40,
  parameter logic [5:0]  KEY_RGB = 6'b110011,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        active,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        flip,
  input  logic        bg_solid,
  output logic [10:0] rom_addr,
  input  logic [5:0]  rom_rgb,
  output logic [5:0]  out_rgb,
  output logic        out_opaque,
  output logic        collide
);

  localparam logic [10:0] W11      = 11'(SPR_W);
  localparam logic [10:0] H11      = 11'(SPR_H);
  localparam logic [10:0] WM1      = 11'(SPR_W - 1);
  localparam logic [10:0] HTOT11   = 11'(H_TOTAL);
  localparam logic [10:0] VTOT11   = 11'(V_TOTAL);

  logic [9:0]  r_shx;
  logic [9:0]  r_shy;
  logic        r_flip;
  logic [10:0] r_rom_addr;
  logic        r_inbox_d1;
  logic        r_inbox_d2;
  logic        r_sticky;
  logic        r_collide;

  logic        w_frame_start;
  logic [10:0] w_hc;
  logic [10:0] w_vc;
  logic [10:0] w_shx;
  logic [10:0] w_shy;
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [10:0] w_col;
  logic [10:0] w_row_base;
  logic [10:0] w_addr;
  logic        w_inbox;
  logic        w_opaque;
  logic        w_hit;

  assign w_frame_start = (hcount == '0) && (vcount == '0);

  assign w_hc  = {1'b0, hcount};
  assign w_vc  = {1'b0, vcount};
  assign w_shx = {1'b0, r_shx};
  assign w_shy = {1'b0, r_shy};
  assign w_dx  = w_hc - w_shx;
  assign w_dy  = w_vc - w_shy;

  // 11-bit compares keep a box near column/row 1023 from wrapping back on-screen.
  assign w_inbox = active
                && (w_hc >= w_shx) && (w_hc < w_shx + W11) && (w_hc < HTOT11)
                && (w_vc >= w_shy) && (w_vc < w_shy + H11) && (w_vc < VTOT11);

  assign w_col = r_flip ? (WM1 - w_dx) : w_dx;

  // Row base dy*SPR_W as a sum of shifted copies of dy, one per set bit of the width.
  always_comb begin
    w_row_base = '0;
    for (int unsigned i = 0; i < 11; i++) begin
      if (W11[i]) begin
        w_row_base = w_row_base + (w_dy << i);
      end
    end
  end

  assign w_addr = w_row_base + w_col;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shx  <= '1;
      r_shy  <= '1;
      r_flip <= 1'b0;
    end else if (w_frame_start) begin
      r_shx  <= sprite_x;
      r_shy  <= sprite_y;
      r_flip <= flip;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_addr <= '0;
      r_inbox_d1 <= 1'b0;
      r_inbox_d2 <= 1'b0;
    end else begin
      if (w_inbox) begin
        r_rom_addr <= w_addr;
      end
      r_inbox_d1 <= w_inbox;
      r_inbox_d2 <= r_inbox_d1;
    end
  end

  assign w_opaque = r_inbox_d2 && (rom_rgb != KEY_RGB);
  assign w_hit    = w_opaque && bg_solid;

  // A hit on the frame-start cycle still belongs to the frame being closed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky  <= 1'b0;
      r_collide <= 1'b0;
    end else if (w_frame_start) begin
      r_collide <= r_sticky | w_hit;
      r_sticky  <= 1'b0;
    end else begin
      r_sticky  <= r_sticky | w_hit;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign out_opaque = w_opaque;
  assign out_rgb    = w_opaque ? rom_rgb : '0;
  assign collide    = r_collide;

endmodule

// File: tb/tb_sprite_fetch.sv
// Bench for sprite_fetch: registered ROM model, table of scan vectors and queued expectations
// for the 1-clock address and 2-clock pixel latencies, plus collision and reset sequences.
module tb_sprite_fetch;

  localparam logic [5:0] KEY = 6'b110011;

  logic        clk;
  logic        rst;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        active;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic        flip;
  logic        bg_solid;
  logic [10:0] rom_addr;
  logic [5:0]  rom_rgb;
  logic [5:0]  out_rgb;
  logic        out_opaque;
  logic        collide;

  sprite_fetch #(
    .SPR_W   (30),
    .SPR_H   (40),
    .KEY_RGB (6'b110011),
    .H_TOTAL (800),
    .V_TOTAL (525)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount     (hcount),
    .vcount     (vcount),
    .active     (active),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .flip       (flip),
    .bg_solid   (bg_solid),
    .rom_addr   (rom_addr),
    .rom_rgb    (rom_rgb),
    .out_rgb    (out_rgb),
    .out_opaque (out_opaque),
    .collide    (collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] rom_f(input logic [10:0] a);
    logic [4:0] lo;
    lo = a[4:0] ^ 5'h15;
    if (a == 11'd5)      return KEY;
    else if (a == 11'd6) return 6'b111111;
    else                 return {1'b0, lo};
  endfunction

  always @(posedge clk) rom_rgb <= rom_f(rom_addr);

  typedef struct {
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        act;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        fl;
    logic        bg;
    logic        inb;
    logic [10:0] addr;
  } vec_t;

  typedef struct {
    logic       opq;
    logic [5:0] rgb;
  } out_t;

  int          total = 0;
  int          bad   = 0;
  logic [10:0] e_last;
  logic [10:0] qa[$];
  out_t        qo[$];
  vec_t        tbl[$];

  function automatic vec_t mk(input int hc, input int vc, input int act, input int sx,
                              input int sy, input int fl, input int bg, input int inb,
                              input int addr);
    vec_t v;
    v.hc = 10'(hc); v.vc = 10'(vc); v.act = 1'(act);
    v.sx = 10'(sx); v.sy = 10'(sy); v.fl = 1'(fl); v.bg = 1'(bg);
    v.inb = 1'(inb); v.addr = 11'(addr);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v, input string nm);
    logic [10:0] ea;
    out_t        eo;
    out_t        no;
    @(negedge clk);
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk({nm, ":rom_addr"}, 32'(rom_addr), 32'(ea));
    end
    if (qo.size() == 2) begin
      eo = qo.pop_front();
      chk({nm, ":out_opaque"}, 32'(out_opaque), 32'(eo.opq));
      chk({nm, ":out_rgb"}, 32'(out_rgb), 32'(eo.rgb));
    end
    hcount = v.hc; vcount = v.vc; active = v.act;
    sprite_x = v.sx; sprite_y = v.sy; flip = v.fl; bg_solid = v.bg;
    if (v.inb) e_last = v.addr;
    qa.push_back(e_last);
    no.opq = v.inb && (rom_f(v.addr) != KEY);
    no.rgb = no.opq ? rom_f(v.addr) : 6'd0;
    qo.push_back(no);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b1;
    qa.delete();
    qo.delete();
    e_last = '0;
    @(negedge clk);
    chk({nm, ":rom_addr"}, 32'(rom_addr), 32'd0);
    chk({nm, ":out_opaque"}, 32'(out_opaque), 32'd0);
    chk({nm, ":out_rgb"}, 32'(out_rgb), 32'd0);
    chk({nm, ":collide"}, 32'(collide), 32'd0);
    rst = 1'b0;
    hcount = 10'd300; vcount = 10'd300; active = 1'b0; bg_solid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hcount = '0; vcount = '0; active = 1'b0;
    sprite_x = 10'd100; sprite_y = 10'd50; flip = 1'b0; bg_solid = 1'b0;
    e_last = '0;

    // 1: basic placement, corners, edges, active masking
    tbl.push_back(mk(0,   0,  1, 100, 50, 0, 0, 0, 0));
    tbl.push_back(mk(100, 50, 1, 100, 50, 0, 0, 1, 0));
    tbl.push_back(mk(129, 89, 1, 100, 50, 0, 0, 1, 1199));
    tbl.push_back(mk(99,  50, 1, 100, 50, 0, 0, 0, 0));
    tbl.push_back(mk(130, 50, 1, 100, 50, 0, 0, 0, 0));
    tbl.push_back(mk(100, 49, 1, 100, 50, 0, 0, 0, 0));
    tbl.push_back(mk(100, 90, 1, 100, 50, 0, 0, 0, 0));
    tbl.push_back(mk(110, 60, 0, 100, 50, 0, 0, 0, 0));
    // 2: flipped
    tbl.push_back(mk(0,   0,  1, 100, 50, 1, 0, 0, 0));
    tbl.push_back(mk(100, 50, 1, 100, 50, 1, 0, 1, 29));
    tbl.push_back(mk(129, 50, 1, 100, 50, 1, 0, 1, 0));
    tbl.push_back(mk(110, 51, 1, 100, 50, 1, 0, 1, 49));
    // 3: transparency key and solid white
    tbl.push_back(mk(0,   0,  1, 100, 50, 0, 0, 0, 0));
    tbl.push_back(mk(105, 50, 1, 100, 50, 0, 0, 1, 5));
    tbl.push_back(mk(106, 50, 1, 100, 50, 0, 0, 1, 6));
    // 4: mid-frame move is shadowed until the next frame start
    tbl.push_back(mk(110, 60, 1, 200, 50, 0, 0, 1, 310));
    tbl.push_back(mk(205, 60, 1, 200, 50, 0, 0, 0, 0));
    tbl.push_back(mk(0,   0,  1, 200, 50, 0, 0, 0, 0));
    tbl.push_back(mk(205, 60, 1, 200, 50, 0, 0, 1, 305));
    tbl.push_back(mk(110, 60, 1, 200, 50, 0, 0, 0, 0));
    // 5: right-edge clipping and no row wrap
    tbl.push_back(mk(0,   0,  1, 625, 50, 0, 0, 0, 0));
    tbl.push_back(mk(625, 50, 1, 625, 50, 0, 0, 1, 0));
    tbl.push_back(mk(639, 50, 1, 625, 50, 0, 0, 1, 14));
    tbl.push_back(mk(640, 50, 0, 625, 50, 0, 0, 0, 0));
    tbl.push_back(mk(654, 50, 0, 625, 50, 0, 0, 0, 0));
    tbl.push_back(mk(0,   51, 1, 625, 50, 0, 0, 0, 0));
    tbl.push_back(mk(0,   0,  1, 790, 50, 0, 0, 0, 0));
    tbl.push_back(mk(795, 50, 0, 790, 50, 0, 0, 0, 0));
    tbl.push_back(mk(5,   51, 1, 790, 50, 0, 0, 0, 0));
    tbl.push_back(mk(0,   50, 1, 790, 50, 0, 0, 0, 0));

    do_reset("reset");
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i], $sformatf("vec%0d", i));
    end

    // 6: collision in frame N shows for all of N+1, clears in N+2
    drive(mk(0,   0,   1, 100, 50, 0, 0, 0, 0),   "colN_fs");
    drive(mk(100, 50,  1, 100, 50, 0, 0, 1, 0),   "colN_px");
    drive(mk(300, 300, 0, 100, 50, 0, 0, 0, 0),   "colN_idle");
    drive(mk(300, 300, 0, 100, 50, 0, 1, 0, 0),   "colN_bg");
    drive(mk(300, 300, 0, 100, 50, 0, 0, 0, 0),   "colN_idle");
    chk("collide_frameN", 32'(collide), 32'd0);
    drive(mk(0,   0,   1, 100, 50, 0, 0, 0, 0),   "colN1_fs");
    drive(mk(300, 300, 0, 100, 50, 0, 0, 0, 0),   "colN1_idle");
    chk("collide_frameN1_early", 32'(collide), 32'd1);
    for (int i = 0; i < 4; i++) drive(mk(300, 300, 0, 100, 50, 0, 0, 0, 0), "colN1_idle");
    chk("collide_frameN1_late", 32'(collide), 32'd1);
    drive(mk(0,   0,   1, 100, 50, 0, 0, 0, 0),   "colN2_fs");
    drive(mk(300, 300, 0, 100, 50, 0, 0, 0, 0),   "colN2_idle");
    chk("collide_frameN2", 32'(collide), 32'd0);

    // hit landing on the frame-start cycle belongs to the closing frame
    drive(mk(100, 50,  1, 100, 50, 0, 0, 1, 0),   "coin_px");
    drive(mk(300, 300, 0, 100, 50, 0, 0, 0, 0),   "coin_idle");
    drive(mk(0,   0,   1, 100, 50, 0, 1, 0, 0),   "coin_fs");
    drive(mk(300, 300, 0, 100, 50, 0, 0, 0, 0),   "coin_idle");
    chk("collide_coincident", 32'(collide), 32'd1);

    // mid-frame reset with pipeline full and collide set
    drive(mk(110, 60,  1, 100, 50, 0, 0, 1, 310), "mid_px");
    drive(mk(111, 60,  1, 100, 50, 0, 0, 1, 311), "mid_px2");
    do_reset("midrst");
    drive(mk(110, 60,  1, 100, 50, 0, 0, 0, 0),   "post_rst");
    drive(mk(111, 60,  1, 100, 50, 0, 0, 0, 0),   "post_rst");
    drive(mk(300, 300, 0, 100, 50, 0, 0, 0, 0),   "post_rst");
    drive(mk(300, 300, 0, 100, 50, 0, 0, 0, 0),   "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
